// File: rtl/despachar_ativo_if.sv
// Handshake bundle between the active-node dispatcher, the classifier and the
// node-table owner. The dispatcher takes the master view.
interface despachar_ativo_if #(
    parameter int NUM_NA         = 8,
    parameter int ADDR_WIDTH     = 8,
    parameter int CRITERIO_WIDTH = 5
);
    logic                             inicio_in;
    logic [NUM_NA-1:0]                na_ativo_in;
    logic [NUM_NA*CRITERIO_WIDTH-1:0] na_criterio_in;
    logic                             ca_pronto_in;
    logic [CRITERIO_WIDTH-1:0]        ca_criterio_geral_in;
    logic                             da_atualizar_out;
    logic                             da_valido_out;
    logic [ADDR_WIDTH-1:0]            da_endereco_out;
    logic                             da_aceito_in;
    logic [NUM_NA-1:0]                da_limpar_out;
    logic                             da_ocupado_out;
    logic                             da_fim_out;
    logic                             da_vazio_out;

    modport master (
        input  inicio_in, na_ativo_in, na_criterio_in, ca_pronto_in,
               ca_criterio_geral_in, da_aceito_in,
        output da_atualizar_out, da_valido_out, da_endereco_out,
               da_limpar_out, da_ocupado_out, da_fim_out, da_vazio_out
    );

    modport slave (
        output inicio_in, na_ativo_in, na_criterio_in, ca_pronto_in,
               ca_criterio_geral_in, da_aceito_in,
        input  da_atualizar_out, da_valido_out, da_endereco_out,
               da_limpar_out, da_ocupado_out, da_fim_out, da_vazio_out
    );
endinterface

// File: rtl/despachar_ativo.sv
// Active-node dispatcher: requests a classifier update, latches the minimum
// criterion, then hands out every active node matching it, one per handshake.
module despachar_ativo #(
    parameter int NUM_NA         = 8,
    parameter int ADDR_WIDTH     = 8,
    parameter int CRITERIO_WIDTH = 5
) (
    input  logic                clk,
    input  logic                rst,
    despachar_ativo_if.master   bus
);
    localparam int IDX_W = $clog2(NUM_NA);
    localparam int CNT_W = $clog2(NUM_NA + 1);

    typedef enum logic [2:0] {
        OCIOSO, ATUALIZAR, ESPERAR, VARRER, OFERTAR, FINAL
    } estado_t;

    estado_t                   estado;
    estado_t                   proximo;
    logic [IDX_W-1:0]          idx;
    logic [CRITERIO_WIDTH-1:0] geral_q;
    logic [CNT_W-1:0]          contagem;
    logic [CRITERIO_WIDTH-1:0] criterio [NUM_NA];
    logic                      casa;
    logic                      ultimo;

    for (genvar g = 0; g < NUM_NA; g++) begin : g_criterio
        assign criterio[g] = bus.na_criterio_in[g*CRITERIO_WIDTH +: CRITERIO_WIDTH];
    end

    // Active flags are looked at live, so a slot retired mid-round is skipped.
    assign casa   = bus.na_ativo_in[idx] && (criterio[idx] == geral_q);
    assign ultimo = (idx == IDX_W'(NUM_NA - 1));

    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) estado <= OCIOSO;
        else     estado <= proximo;
    end

    // NOTE: proximo gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        proximo = estado;
        case (estado)
            OCIOSO:    if (bus.inicio_in) proximo = ATUALIZAR;
            ATUALIZAR: proximo = ESPERAR;
            ESPERAR:   if (bus.ca_pronto_in) proximo = VARRER;
            VARRER: begin
                if (casa)        proximo = OFERTAR;
                else if (ultimo) proximo = FINAL;
            end
            OFERTAR:   if (bus.da_aceito_in) proximo = ultimo ? FINAL : VARRER;
            FINAL:     proximo = OCIOSO;
            default:   proximo = OCIOSO;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx                 <= '0;
            geral_q             <= '1;
            contagem            <= '0;
            bus.da_valido_out   <= 1'b0;
            bus.da_endereco_out <= '0;
            bus.da_limpar_out   <= '0;
            bus.da_vazio_out    <= 1'b0;
        end else begin
            bus.da_limpar_out <= '0;
            case (estado)
                OCIOSO: begin
                    if (bus.inicio_in) begin
                        bus.da_vazio_out <= 1'b0;
                        contagem         <= '0;
                    end
                end
                ESPERAR: begin
                    if (bus.ca_pronto_in) begin
                        geral_q <= bus.ca_criterio_geral_in;
                        idx     <= '0;
                    end
                end
                VARRER: begin
                    if (casa) begin
                        bus.da_endereco_out <= ADDR_WIDTH'(idx);
                        bus.da_valido_out   <= 1'b1;
                    end else if (!ultimo) begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                OFERTAR: begin
                    if (bus.da_aceito_in) begin
                        bus.da_valido_out <= 1'b0;
                        bus.da_limpar_out <= NUM_NA'(1) << idx;
                        contagem          <= contagem + CNT_W'(1);
                        if (!ultimo) idx <= idx + IDX_W'(1);
                    end
                end
                FINAL:   bus.da_vazio_out <= (contagem == '0);
                default: ;
            endcase
        end
    end

    assign bus.da_atualizar_out = (estado == ATUALIZAR);
    assign bus.da_ocupado_out   = (estado != OCIOSO);
    assign bus.da_fim_out       = (estado == FINAL);
endmodule

// File: tb/tb_despachar_ativo.sv
// Scoreboard bench for despachar_ativo: directed tables, a small classifier
// responder, and a monitor that checks each accepted dispatch, clear and end flag.
module tb_despachar_ativo;
    localparam int NUM_NA = 8;
    localparam int AW     = 8;
    localparam int CW     = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    despachar_ativo_if #(.NUM_NA(NUM_NA), .ADDR_WIDTH(AW), .CRITERIO_WIDTH(CW)) bus ();

    despachar_ativo #(.NUM_NA(NUM_NA), .ADDR_WIDTH(AW), .CRITERIO_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int n_pass  = 0;
    int n_total = 0;

    logic [AW-1:0]     exp_addr   [$];
    logic [NUM_NA-1:0] exp_limpar [$];
    logic              exp_vazio  [$];

    int cnt_atualizar = 0;
    int cnt_valido    = 0;
    int cnt_limpar    = 0;
    int cnt_fim       = 0;

    int          cls_delay = 3;
    logic [CW-1:0] cls_geral = '1;

    logic              pend_l = 1'b0;
    logic [NUM_NA-1:0] pend_lv = '0;
    logic              pend_v = 1'b0;
    logic              pend_vv = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    task automatic flag(input string name, input logic [63:0] act);
        n_total++;
        $display("FAIL %s: got 0x%0h, required no such event", name, act);
    endtask

    task automatic fill_crit(input logic [CW-1:0] v);
        for (int i = 0; i < NUM_NA; i++) bus.na_criterio_in[i*CW +: CW] = v;
    endtask

    task automatic set_crit(input int slot, input logic [CW-1:0] v);
        bus.na_criterio_in[slot*CW +: CW] = v;
    endtask

    task automatic wait_fim(input string name, input int budget, inout int lat);
        bit seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            lat++;
            if (bus.da_fim_out) begin seen = 1; break; end
        end
        if (!seen) flag({name, "_fim_timeout"}, 64'(lat));
    endtask

    task automatic wait_valido(input string name, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.da_valido_out) begin seen = 1; break; end
        end
        if (!seen) flag({name, "_valido_timeout"}, 64'(budget));
    endtask

    // Pulses inicio for one cycle; lat counts cycles from the inicio cycle to the fim cycle inclusive.
    task automatic run_round(input string name, input int budget, output int lat);
        @(posedge clk); #1 bus.inicio_in = 1'b1;
        @(negedge clk);
        lat = 1;
        @(posedge clk); #1 bus.inicio_in = 1'b0;
        wait_fim(name, budget, lat);
    endtask

    task automatic start_round();
        @(posedge clk); #1 bus.inicio_in = 1'b1;
        @(posedge clk); #1 bus.inicio_in = 1'b0;
    endtask

    task automatic check_drained(input string name);
        repeat (2) @(negedge clk);
        check({name, "_pending"}, 64'(exp_addr.size() + exp_limpar.size() + exp_vazio.size()), 64'd0);
    endtask

    // Classifier responder: drops ready on the update request, reasserts it later with the minimum.
    initial begin
        bus.ca_pronto_in         = 1'b0;
        bus.ca_criterio_geral_in = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst && bus.da_atualizar_out) begin
                bus.ca_pronto_in = 1'b0;
                repeat (cls_delay) @(posedge clk);
                #1;
                bus.ca_criterio_geral_in = cls_geral;
                bus.ca_pronto_in         = 1'b1;
            end
        end
    end

    // Monitor: consumes expectations whenever the DUT transfers, clears or ends a round.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                pend_l = 1'b0;
                pend_v = 1'b0;
            end else begin
                if (bus.da_atualizar_out) cnt_atualizar++;
                if (bus.da_valido_out) cnt_valido++;
                if (bus.da_limpar_out != '0) cnt_limpar++;
                if (pend_l) begin
                    check("limpar", 64'(bus.da_limpar_out), 64'(pend_lv));
                    pend_l = 1'b0;
                end else if (bus.da_limpar_out != '0) begin
                    flag("stray_limpar", 64'(bus.da_limpar_out));
                end
                if (pend_v) begin
                    check("vazio", 64'(bus.da_vazio_out), 64'(pend_vv));
                    pend_v = 1'b0;
                end
                if (bus.da_valido_out && bus.da_aceito_in) begin
                    if (exp_addr.size() == 0 || exp_limpar.size() == 0) begin
                        flag("unexpected_dispatch", 64'(bus.da_endereco_out));
                    end else begin
                        check("endereco", 64'(bus.da_endereco_out), 64'(exp_addr.pop_front()));
                        pend_lv = exp_limpar.pop_front();
                        pend_l  = 1'b1;
                    end
                end
                if (bus.da_fim_out) begin
                    cnt_fim++;
                    if (exp_vazio.size() == 0) begin
                        flag("unexpected_fim", 64'(bus.da_vazio_out));
                    end else begin
                        pend_vv = exp_vazio.pop_front();
                        pend_v  = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        int lat;
        int a0, f0, v0, l0;

        rst              = 1'b1;
        bus.inicio_in    = 1'b0;
        bus.na_ativo_in  = '0;
        bus.na_criterio_in = '0;
        bus.da_aceito_in = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valido",    64'(bus.da_valido_out),    64'd0);
        check("rst_limpar",    64'(bus.da_limpar_out),    64'd0);
        check("rst_ocupado",   64'(bus.da_ocupado_out),   64'd0);
        check("rst_fim",       64'(bus.da_fim_out),       64'd0);
        check("rst_vazio",     64'(bus.da_vazio_out),     64'd0);
        check("rst_atualizar", 64'(bus.da_atualizar_out), 64'd0);
        check("rst_endereco",  64'(bus.da_endereco_out),  64'd0);
        @(posedge clk); #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_ocupado", 64'(bus.da_ocupado_out), 64'd0);

        // Basic round: slots 1,2,5 active with 7,3,3; minimum 3 -> 2 then 5
        bus.na_ativo_in = 8'b0010_0110;
        fill_crit(5'h1f);
        set_crit(1, 5'd7); set_crit(2, 5'd3); set_crit(5, 5'd3);
        cls_geral = 5'd3; cls_delay = 2;
        bus.da_aceito_in = 1'b1;
        exp_addr.push_back(8'd2);  exp_limpar.push_back(8'h04);
        exp_addr.push_back(8'd5);  exp_limpar.push_back(8'h20);
        exp_vazio.push_back(1'b0);
        a0 = cnt_atualizar; f0 = cnt_fim;
        run_round("basic", 60, lat);
        check_drained("basic");
        check("basic_atualizar_pulses", 64'(cnt_atualizar - a0), 64'd1);
        check("basic_fim_pulses",       64'(cnt_fim - f0),       64'd1);

        // Empty table: nothing active, slot 0 criterion 0 equals the minimum
        bus.na_ativo_in = '0;
        fill_crit(5'd0);
        cls_geral = 5'd0; cls_delay = 3;
        exp_vazio.push_back(1'b1);
        v0 = cnt_valido; l0 = cnt_limpar;
        run_round("empty", 60, lat);
        check("empty_latency", 64'(lat), 64'(3 + 3 + NUM_NA));
        check_drained("empty");
        check("empty_no_valido", 64'(cnt_valido - v0), 64'd0);
        check("empty_no_limpar", 64'(cnt_limpar - l0), 64'd0);

        // Backpressure: single match at slot 7, accept withheld for 5 cycles
        bus.na_ativo_in = 8'h80;
        fill_crit(5'h1f);
        set_crit(7, 5'd2);
        cls_geral = 5'd2; cls_delay = 1;
        bus.da_aceito_in = 1'b0;
        exp_addr.push_back(8'd7); exp_limpar.push_back(8'h80);
        exp_vazio.push_back(1'b0);
        start_round();
        wait_valido("bp", 40);
        check("bp_vazio_cleared", 64'(bus.da_vazio_out), 64'd0);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("bp_valido_held",   64'(bus.da_valido_out),   64'd1);
            check("bp_endereco_held", 64'(bus.da_endereco_out), 64'd7);
        end
        @(posedge clk); #1 bus.da_aceito_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_fim_after_accept",    64'(bus.da_fim_out),    64'd1);
        check("bp_valido_after_accept", 64'(bus.da_valido_out), 64'd0);
        check_drained("bp");

        // Stale ready: ready still high with old minimum 2, which would select slot 1
        bus.na_ativo_in = 8'h12;
        fill_crit(5'h1f);
        set_crit(1, 5'd2); set_crit(4, 5'd1);
        cls_geral = 5'd1; cls_delay = 6;
        bus.da_aceito_in = 1'b1;
        exp_addr.push_back(8'd4); exp_limpar.push_back(8'h10);
        exp_vazio.push_back(1'b0);
        a0 = cnt_atualizar;
        start_round();
        @(posedge clk); #1 bus.inicio_in = 1'b1;
        @(posedge clk); #1 bus.inicio_in = 1'b0;
        @(negedge clk);
        check("stale_waiting_ocupado", 64'(bus.da_ocupado_out), 64'd1);
        check("stale_waiting_valido",  64'(bus.da_valido_out),  64'd0);
        lat = 0;
        wait_fim("stale", 60, lat);
        check_drained("stale");
        check("stale_atualizar_pulses", 64'(cnt_atualizar - a0), 64'd1);

        // Live deactivation: slots 3 and 4 match, slot 4 retired while 3 is offered
        bus.na_ativo_in = 8'h18;
        fill_crit(5'h1f);
        set_crit(3, 5'd4); set_crit(4, 5'd4);
        cls_geral = 5'd4; cls_delay = 2;
        bus.da_aceito_in = 1'b0;
        exp_addr.push_back(8'd3); exp_limpar.push_back(8'h08);
        exp_vazio.push_back(1'b0);
        start_round();
        wait_valido("live", 40);
        @(posedge clk); #1;
        bus.na_ativo_in  = 8'h08;
        bus.da_aceito_in = 1'b1;
        lat = 0;
        wait_fim("live", 40, lat);
        check_drained("live");

        // Reset while an address is being offered
        bus.na_ativo_in = 8'b0010_0110;
        fill_crit(5'h1f);
        set_crit(1, 5'd7); set_crit(2, 5'd3); set_crit(5, 5'd3);
        cls_geral = 5'd3; cls_delay = 2;
        bus.da_aceito_in = 1'b0;
        start_round();
        wait_valido("rstmid", 40);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rstmid_valido",  64'(bus.da_valido_out),  64'd0);
        check("rstmid_limpar",  64'(bus.da_limpar_out),  64'd0);
        check("rstmid_ocupado", 64'(bus.da_ocupado_out), 64'd0);
        check("rstmid_fim",     64'(bus.da_fim_out),     64'd0);
        @(posedge clk); #2 rst = 1'b0;
        bus.da_aceito_in = 1'b1;
        exp_addr.push_back(8'd2);  exp_limpar.push_back(8'h04);
        exp_addr.push_back(8'd5);  exp_limpar.push_back(8'h20);
        exp_vazio.push_back(1'b0);
        f0 = cnt_fim;
        run_round("after_rst", 60, lat);
        check_drained("after_rst");
        check("after_rst_fim_pulses", 64'(cnt_fim - f0), 64'd1);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
